// File: rtl/dct_block_sequencer.sv
// Sequences one bank of 8 DA DCT lanes: accept block, clear/enable/drain lanes, stream z0..z7.
// Latency accept->first coef = DA_CYCLES+PIPE_LAT+2 cycles; one block in flight, output stalls hold coef_data/coef_idx.
module dct_block_sequencer #(
  parameter int SAMP_W    = 8,
  parameter int COEF_W    = 19,
  parameter int DA_CYCLES = 8,
  parameter int PIPE_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*SAMP_W-1:0]   in_block,
  output logic [8*SAMP_W-1:0]   samp_bus,
  output logic                  lane_clr,
  output logic                  lane_en,
  output logic                  rom_cs,
  input  logic [8*COEF_W-1:0]   lane_out,
  output logic                  coef_valid,
  input  logic                  coef_ready,
  output logic [COEF_W-1:0]     coef_data,
  output logic [2:0]            coef_idx,
  output logic                  coef_last,
  output logic                  busy,
  output logic [15:0]           blk_count
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, OUT} state_t;

  localparam logic [3:0] STEP_LAST  = 4'(DA_CYCLES - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT - 1);

  state_t            state, state_d;
  logic [3:0]        step, step_d;
  logic [2:0]        drain, drain_d;
  logic [2:0]        idx_d;
  logic [15:0]       blk_d;
  logic              capture;
  logic              accept;
  logic              clr_d, en_d, cs_d, vld_d, last_d, busy_d;
  logic [COEF_W-1:0] cap [8];

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state;
    step_d  = step;
    drain_d = drain;
    idx_d   = coef_idx;
    blk_d   = blk_count;
    capture = 1'b0;
    case (state)
      IDLE: begin
        step_d  = '0;
        drain_d = '0;
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        step_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        if (step == STEP_LAST) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          step_d = step + 4'd1;
        end
      end
      DRAIN: begin
        // Lane results are only valid once the ROM/accumulate pipe has flushed.
        if (drain == DRAIN_LAST) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = OUT;
        end else begin
          drain_d = drain + 3'd1;
        end
      end
      OUT: begin
        if (coef_ready) begin
          if (coef_idx == 3'd7) begin
            idx_d   = '0;
            blk_d   = blk_count + 16'd1;
            state_d = IDLE;
          end else begin
            idx_d = coef_idx + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Control outputs are registered from the next state so they align with it.
    clr_d  = (state_d == LOAD);
    en_d   = (state_d == RUN);
    cs_d   = (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN);
    vld_d  = (state_d == OUT);
    last_d = (state_d == OUT) && (idx_d == 3'd7);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      step       <= '0;
      drain      <= '0;
      coef_idx   <= '0;
      blk_count  <= '0;
      samp_bus   <= '0;
      lane_clr   <= 1'b0;
      lane_en    <= 1'b0;
      rom_cs     <= 1'b0;
      coef_valid <= 1'b0;
      coef_last  <= 1'b0;
      busy       <= 1'b0;
      for (int k = 0; k < 8; k++) cap[k] <= '0;
    end else begin
      state      <= state_d;
      step       <= step_d;
      drain      <= drain_d;
      coef_idx   <= idx_d;
      blk_count  <= blk_d;
      lane_clr   <= clr_d;
      lane_en    <= en_d;
      rom_cs     <= cs_d;
      coef_valid <= vld_d;
      coef_last  <= last_d;
      busy       <= busy_d;
      if (accept) samp_bus <= in_block;
      if (capture) begin
        for (int k = 0; k < 8; k++) cap[k] <= lane_out[k*COEF_W +: COEF_W];
      end
    end
  end

  always_comb begin
    coef_data = cap[coef_idx];
  end

endmodule
